// File: rtl/frame_serializer_if.sv
// Word-in / bit-out bus of the frame serializer: parallel word handshake
// on one side, serial line and frame status on the other.
interface frame_serializer_if;
  logic [7:0] d;
  logic [1:0] m;
  logic       lsb_first;
  logic       valid;
  logic       ready;
  logic       so;
  logic       busy;
  logic       done;

  modport master (
    output d, m, lsb_first, valid,
    input  ready, so, busy, done
  );

  modport slave (
    input  d, m, lsb_first, valid,
    output ready, so, busy, done
  );
endinterface

// File: rtl/frame_serializer.sv
// Serializes one 8-bit word per handshake into a raw, start/stop or
// start/parity/stop frame, each bit held DIV clock cycles.
module frame_serializer #(
  parameter int DIV   = 1,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_serializer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic [1:0]         mode_reg, mode_next;
  logic               lsb_reg, lsb_next;
  logic [2:0]         idx_reg, idx_next;
  logic               so_reg, so_next;
  logic               done_reg, done_next;
  logic               tick;

  function automatic logic pick(input logic [WIDTH-1:0] w, input logic lsb,
                                input logic [2:0] i);
    return lsb ? w[i] : w[3'd7 - i];
  endfunction

  // tick marks the last cycle of the current bit period
  generate
    if (DIV <= 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int CW = $clog2(DIV);
      logic [CW-1:0] div_cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          div_cnt_reg <= '0;
        else if (state_reg == IDLE || tick)
          div_cnt_reg <= '0;
        else
          div_cnt_reg <= div_cnt_reg + CW'(1);
      end
      assign tick = (div_cnt_reg == CW'(DIV - 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      mode_reg  <= 2'b00;
      lsb_reg   <= 1'b0;
      idx_reg   <= 3'd0;
      so_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      mode_reg  <= mode_next;
      lsb_reg   <= lsb_next;
      idx_reg   <= idx_next;
      so_reg    <= so_next;
      done_reg  <= done_next;
    end
  end

  // so_next always carries the bit that is on the line after the coming edge
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    mode_next  = mode_reg;
    lsb_next   = lsb_reg;
    idx_next   = idx_reg;
    so_next    = so_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        so_next = 1'b1;
        if (bus.valid) begin
          data_next = bus.d;
          mode_next = bus.m;
          lsb_next  = bus.lsb_first;
          idx_next  = 3'd0;
          if (bus.m == 2'b00) begin
            state_next = DATA;
            so_next    = pick(bus.d, bus.lsb_first, 3'd0);
          end else begin
            state_next = START;
            so_next    = 1'b0;
          end
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          idx_next   = 3'd0;
          so_next    = pick(data_reg, lsb_reg, 3'd0);
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_reg == 3'd7) begin
            if (mode_reg[1]) begin
              state_next = PARITY;
              so_next    = (^data_reg) ^ mode_reg[0];
            end else if (mode_reg == 2'b01) begin
              state_next = STOP;
              so_next    = 1'b1;
            end else begin
              state_next = IDLE;
              so_next    = 1'b1;
              done_next  = 1'b1;
            end
          end else begin
            idx_next = idx_reg + 3'd1;
            so_next  = pick(data_reg, lsb_reg, idx_reg + 3'd1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          so_next    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          so_next    = 1'b1;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        so_next    = 1'b1;
      end
    endcase
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.busy  = (state_reg != IDLE);
  assign bus.so    = so_reg;
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_frame_serializer.sv
// Random and directed frames into a DIV=1 and a DIV=4 serializer; a
// per-instance monitor checks every serial cycle against queued frames.
module tb_frame_serializer;

  typedef struct {
    logic [10:0] bits;
    int          n;
    logic [7:0]  d;
    logic [1:0]  m;
    logic        lsb;
  } frame_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  frame_t exp_q_a[$];
  frame_t exp_q_b[$];

  bit     active[2];
  bit     done_due[2];
  int     cyc[2];
  int     fail_mark[2];
  frame_t cur[2];
  int     div_of[2] = '{1, 4};

  always #5 clk = ~clk;

  frame_serializer_if bus_a();
  frame_serializer_if bus_b();

  frame_serializer #(.DIV(1)) dut_a (.clk(clk), .rst_n(rst_a_n), .bus(bus_a.slave));
  frame_serializer #(.DIV(4)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(bus_b.slave));

  task automatic chk(input int k, input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL dut%0d %s: got %b, want %b (t=%0t)", k, name, act, req, $time);
    end
  endtask

  // Frame as the line should show it, bit 0 first in time
  function automatic frame_t model(input logic [7:0] d, input logic [1:0] m, input logic lsb);
    frame_t f;
    f.bits = '1;
    f.n    = 0;
    f.d    = d;
    f.m    = m;
    f.lsb  = lsb;
    if (m != 2'b00) begin
      f.bits[f.n] = 1'b0;
      f.n++;
    end
    for (int i = 0; i < 8; i++) begin
      f.bits[f.n] = lsb ? d[i] : d[7-i];
      f.n++;
    end
    if (m[1]) begin
      f.bits[f.n] = (($countones(d) % 2) == 1) ^ m[0];
      f.n++;
    end
    if (m != 2'b00) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    return f;
  endfunction

  task automatic mon_step(input int k, input logic rstn, input logic rdy,
                          input logic bsy, input logic dn, input logic s);
    if (!rstn) begin
      active[k]   = 1'b0;
      done_due[k] = 1'b0;
      return;
    end
    if (done_due[k]) begin
      chk(k, "done_pulse", dn, 1'b1);
      chk(k, "done_ready", rdy, 1'b1);
      chk(k, "done_so", s, 1'b1);
      chk(k, "done_busy", bsy, 1'b0);
      done_due[k] = 1'b0;
      $display("[TB] dut%0d frame d=%02h m=%b lsb=%b bits=%0d %s", k, cur[k].d,
               cur[k].m, cur[k].lsb, cur[k].n, (fails == fail_mark[k]) ? "ok" : "bad");
    end else if (!active[k]) begin
      if (rdy) begin
        chk(k, "idle_done", dn, 1'b0);
        chk(k, "idle_so", s, 1'b1);
        chk(k, "idle_busy", bsy, 1'b0);
      end else if ((k == 0 && exp_q_a.size() == 0) || (k == 1 && exp_q_b.size() == 0)) begin
        chk(k, "spurious_accept", rdy, 1'b1);
      end else begin
        cur[k]       = (k == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
        active[k]    = 1'b1;
        cyc[k]       = 0;
        fail_mark[k] = fails;
      end
    end
    if (active[k]) begin
      chk(k, $sformatf("so_bit%0d", cyc[k] / div_of[k]), s, cur[k].bits[cyc[k] / div_of[k]]);
      chk(k, "frame_ready", rdy, 1'b0);
      chk(k, "frame_busy", bsy, 1'b1);
      chk(k, "frame_done", dn, 1'b0);
      cyc[k]++;
      if (cyc[k] == cur[k].n * div_of[k]) begin
        active[k]   = 1'b0;
        done_due[k] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) mon_step(0, rst_a_n, bus_a.ready, bus_a.busy, bus_a.done, bus_a.so);
  always @(negedge clk) mon_step(1, rst_b_n, bus_b.ready, bus_b.busy, bus_b.done, bus_b.so);

  task automatic drive(input int k, input logic [7:0] d, input logic [1:0] m,
                       input logic lsb, input logic v);
    if (k == 0) begin
      bus_a.d = d; bus_a.m = m; bus_a.lsb_first = lsb; bus_a.valid = v;
    end else begin
      bus_b.d = d; bus_b.m = m; bus_b.lsb_first = lsb; bus_b.valid = v;
    end
  endtask

  task automatic set_valid(input int k, input logic v);
    if (k == 0) bus_a.valid = v;
    else        bus_b.valid = v;
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic [1:0] m,
                      input logic lsb, input bit hold);
    logic rdy;
    int   guard;
    guard = 0;
    @(negedge clk);
    drive(k, d, m, lsb, 1'b1);
    forever begin
      rdy = (k == 0) ? bus_a.ready : bus_b.ready;
      if (rdy) break;
      guard++;
      if (guard > 2000) break;
      @(negedge clk);
    end
    chk(k, "accept_timeout", rdy, 1'b1);
    if (rdy) begin
      if (k == 0) exp_q_a.push_back(model(d, m, lsb));
      else        exp_q_b.push_back(model(d, m, lsb));
    end
    @(posedge clk);
    #1;
    if (!hold) set_valid(k, 1'b0);
  endtask

  task automatic random_frames(input int k, input int count);
    bit hold;
    for (int i = 0; i < count; i++) begin
      hold = (i != count - 1) && ($urandom_range(0, 3) == 0);
      send(k, 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 8'h00, 2'b00, 1'b0, 1'b0);
    drive(1, 8'h00, 2'b00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk(0, "rst_so", bus_a.so, 1'b1);
    chk(0, "rst_ready", bus_a.ready, 1'b1);
    chk(0, "rst_busy", bus_a.busy, 1'b0);
    chk(0, "rst_done", bus_a.done, 1'b0);
    chk(1, "rst_so", bus_b.so, 1'b1);
    chk(1, "rst_ready", bus_b.ready, 1'b1);
    chk(1, "rst_busy", bus_b.busy, 1'b0);
    chk(1, "rst_done", bus_b.done, 1'b0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    fork
      begin
        send(0, 8'b0101_0100, 2'b01, 1'b1, 1'b0);
        send(0, 8'b1010_1011, 2'b10, 1'b0, 1'b0);
        send(0, 8'b1010_1011, 2'b11, 1'b0, 1'b0);
        send(0, 8'b0000_0000, 2'b00, 1'b1, 1'b0);
        // abort while data bit 3 is on the line
        send(0, 8'h5A, 2'b01, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_a_n = 1'b0;
        #1;
        chk(0, "abort_so", bus_a.so, 1'b1);
        chk(0, "abort_ready", bus_a.ready, 1'b1);
        chk(0, "abort_busy", bus_a.busy, 1'b0);
        chk(0, "abort_done", bus_a.done, 1'b0);
        exp_q_a.delete();
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        send(0, 8'b1010_1011, 2'b01, 1'b1, 1'b0);
        random_frames(0, 40);
      end
      begin
        // valid held across the first frame: second accept follows one idle cycle
        send(1, 8'b0101_0100, 2'b11, 1'b1, 1'b1);
        send(1, 8'hC3, 2'b01, 1'b0, 1'b0);
        // a word offered while busy must be dropped
        send(1, 8'h3C, 2'b10, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        drive(1, 8'hFF, 2'b00, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        set_valid(1, 1'b0);
        random_frames(1, 25);
      end
    join

    for (int i = 0; i < 3000; i++) begin
      if (exp_q_a.size() == 0 && exp_q_b.size() == 0 && !active[0] && !active[1]
          && !done_due[0] && !done_due[1]) break;
      @(negedge clk);
    end
    chk(0, "drain_a", (exp_q_a.size() == 0 && !active[0] && !done_due[0]), 1'b1);
    chk(1, "drain_b", (exp_q_b.size() == 0 && !active[1] && !done_due[1]), 1'b1);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
